// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU request arbiter.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StResp
  } state_e;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam int unsigned DRAIN_CYCLES = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after i_ptr.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_valid
);

  always_comb begin
    logic [IDX_W-1:0] w_j;
    o_grant = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_j     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_j = IDX_W'((32'(i_ptr) + k) % NUM_REQ);
      if (i_en && !o_valid && i_req[w_j]) begin
        o_grant[w_j] = 1'b1;
        o_idx        = w_j;
        o_valid      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates NUM_REQ requesters onto one multi-cycle ALU, with timeout and
// a post-issue drain window that masks stale alu_done pulses.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [3*NUM_REQ-1:0]         i_req_op,
  input  logic [8*NUM_REQ-1:0]         i_req_a,
  input  logic [8*NUM_REQ-1:0]         i_req_b,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_rsp_valid,
  input  logic                         i_rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]   o_rsp_id,
  output logic [15:0]                  o_rsp_result,
  output logic                         o_rsp_timeout,
  output logic [7:0]                   o_alu_a,
  output logic [7:0]                   o_alu_b,
  output logic [2:0]                   o_alu_op,
  output logic                         o_alu_start,
  input  logic                         i_alu_done,
  input  logic [15:0]                  i_alu_result,
  output logic                         o_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

  state_e             r_state, w_state_d;
  logic [IDX_W-1:0]   r_ptr;
  logic [2:0]         r_drain;
  logic [TMR_W-1:0]   r_timer;
  logic [IDX_W-1:0]   r_id;
  logic [15:0]        r_result;
  logic               r_timeout;
  logic [7:0]         r_alu_a, r_alu_b;
  logic [2:0]         r_alu_op;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_gnt_idx;
  logic               w_gnt_valid;
  logic               w_gnt_en;
  logic [2:0]         w_gnt_op;
  logic [7:0]         w_gnt_a, w_gnt_b;
  logic               w_done;
  logic               w_timeout;

  // Gating with reset keeps req_ready low while reset is held.
  assign w_gnt_en = (r_state == StIdle) && (r_drain == 3'd0) && i_rst_n;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req   (i_req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_gnt_en),
    .o_grant (w_grant),
    .o_idx   (w_gnt_idx),
    .o_valid (w_gnt_valid)
  );

  always_comb begin
    w_gnt_op = '0;
    w_gnt_a  = '0;
    w_gnt_b  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_op = i_req_op[3*i +: 3];
        w_gnt_a  = i_req_a[8*i +: 8];
        w_gnt_b  = i_req_b[8*i +: 8];
      end
    end
  end

  assign w_done    = (r_state == StIssue) && i_alu_done && (r_drain == 3'd0);
  assign w_timeout = (r_state == StIssue) && !w_done && (r_timer == TMR_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:  if (w_gnt_valid) w_state_d = (w_gnt_op == OP_NOP) ? StResp : StIssue;
      StIssue: if (w_done || w_timeout) w_state_d = StResp;
      StResp:  if (i_rsp_ready) w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_alu_start = (r_state == StIssue);
    o_rsp_valid = (r_state == StResp);
    o_busy      = (r_state != StIdle);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr     <= '0;
      r_drain   <= '0;
      r_timer   <= '0;
      r_id      <= '0;
      r_result  <= '0;
      r_timeout <= 1'b0;
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
    end else begin
      r_timer <= (r_state == StIssue) ? r_timer + 1'b1 : '0;

      if (w_done || w_timeout) begin
        r_drain <= 3'(DRAIN_CYCLES);
      end else if (r_drain != 3'd0) begin
        r_drain <= r_drain - 3'd1;
      end

      if (w_gnt_valid) begin
        r_id  <= w_gnt_idx;
        r_ptr <= (w_gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + 1'b1;
        if (w_gnt_op == OP_NOP) begin
          r_result  <= '0;
          r_timeout <= 1'b0;
        end else begin
          // ALU operand registers only change when an op is actually issued.
          r_alu_op <= w_gnt_op;
          r_alu_a  <= w_gnt_a;
          r_alu_b  <= w_gnt_b;
        end
      end

      if (w_done) begin
        r_result  <= i_alu_result;
        r_timeout <= 1'b0;
      end else if (w_timeout) begin
        r_result  <= '0;
        r_timeout <= 1'b1;
      end
    end
  end

  assign o_req_ready   = w_grant;
  assign o_rsp_id      = r_id;
  assign o_rsp_result  = r_result;
  assign o_rsp_timeout = r_timeout;
  assign o_alu_a       = r_alu_a;
  assign o_alu_b       = r_alu_b;
  assign o_alu_op      = r_alu_op;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter TIMEOUT, default 15, max cycles alu_start held awaiting alu_done.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  NUM_REQ  per-requester operation pending.
REQ-006 req_op  input  3*NUM_REQ  per-requester opcode, slice i = bits [3i+2:3i].
REQ-007 req_a, req_b  input  8*NUM_REQ each  per-requester operands.
REQ-008 req_ready  output  NUM_REQ  one-hot accept pulse.
REQ-009 rsp_valid  output  1  response available; rsp_ready  input  1  response taken.
REQ-010 rsp_id  output  $clog2(NUM_REQ)  requester index of response.
REQ-011 rsp_result  output  16  operation result; rsp_timeout  output  1  op aborted.
REQ-012 alu_a, alu_b  output  8; alu_op  output  3; alu_start  output  1  ALU command.
REQ-013 alu_done  input  1; alu_result  input  16  ALU completion.
REQ-014 busy  output  1  high in any state except IDLE.

Function
REQ-015 FSM states IDLE, ISSUE, RESP; independent drain counter (3 bits).
REQ-016 IDLE: when any req_valid and drain counter zero, grant one requester round-robin, starting at (last grant + 1) mod NUM_REQ; first grant after reset searches from index 0.
REQ-017 Grant: req_ready[i] high for exactly that cycle; op/a/b latched on that edge; no grant in any other state.
REQ-018 Granted op 000 (NOP): go directly to RESP, rsp_result 0, rsp_timeout 0; alu_start never asserted.
REQ-019 Other ops: ISSUE next cycle; alu_start high and alu_a/alu_b/alu_op stable throughout ISSUE.
REQ-020 ISSUE: alu_done sampled high -> capture alu_result, drop alu_start next cycle, enter RESP, load drain counter with 4.
REQ-021 ISSUE timeout: alu_done low for TIMEOUT consecutive ISSUE cycles -> drop alu_start, RESP with rsp_result 0, rsp_timeout 1, drain counter 4.
REQ-022 Drain counter decrements every cycle while nonzero; alu_done ignored while nonzero (ALU emits stale done pulses after start drops).
REQ-023 RESP: rsp_valid, rsp_id, rsp_result, rsp_timeout held stable until rsp_valid && rsp_ready sampled, then IDLE.
REQ-024 Latency ADD (001) with immediate rsp_ready: grant edge cycle 0, alu_start cycles 1-2, rsp_valid cycle 3.
REQ-025 alu_a/alu_b/alu_op hold last issued values outside ISSUE; alu_start low outside ISSUE.
REQ-026 req_valid deasserted by a requester before grant simply removes it from arbitration.
REQ-027 Opcodes 101-111 pass through unchanged (ALU treats op[2] as multiply).

Reset
REQ-028 reset_n low: state IDLE, drain counter 0, round-robin pointer to index 0, all outputs 0, asynchronously including mid-ISSUE.
REQ-029 First grant occurs no earlier than the first rising edge after reset_n deasserts.

Structure
REQ-030 Package alu_arbiter_pkg holds state enum, opcode constants (NOP 000, ADD 001, AND 010, XOR 011, MUL 100), DRAIN_CYCLES = 4.
REQ-031 Round-robin grant logic lives in one sub-module rr_arbiter (request vector, pointer, enable in; one-hot grant, index out).

Verification
REQ-032 req_valid[0], op 001, A 8'h12, B 8'h34 -> rsp_id 0, rsp_result 16'h0046, rsp_timeout 0, rsp_valid cycle 3.
REQ-033 req_valid = 4'b1111, all op 100, A 8'hFF, B 8'hFF, held -> grants 0,1,2,3,0 in order, each rsp_result 16'hFE01.
REQ-034 req_valid[2], op 000 -> rsp_id 2, rsp_result 0 one cycle after grant, alu_start never high.
REQ-035 ALU model never asserts alu_done, TIMEOUT 15 -> alu_start high 15 cycles, rsp_timeout 1, rsp_result 0.
REQ-036 rsp_ready low 10 cycles with req_valid[1] pending -> rsp fields stable, req_ready stays 0, grant 1 after handshake.
REQ-037 reset_n low during ISSUE of op 100 -> alu_start, busy, rsp_valid 0 immediately; next grant from index 0.
